memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, data-bus byte address width.
REQ-002 Parameter: DATA_WIDTH, 64, data-bus word width.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 MEM_valid_in  in  1  execute output valid; connected to execute's ex_ready.
REQ-006 MEM_alures_in  in  32  ALU result: effective address for memory ops, result for all others.
REQ-007 MEM_valD_in  in  64  store data; [31:0] is the single-word source.
REQ-008 MEM_op_in / MEM_op3_in  in  2 / 6  SPARC op and op3 fields.
REQ-009 MEM_regD_in, MEM_regWrite_in, MEM_regWriteDouble_in  in  5,1,1  destination and write enables.
REQ-010 mem_ready  out  1  stage can accept this cycle; drives execute's mem_ready.
REQ-011 dmem_req, dmem_we  out  1,1  bus request and write strobe.
REQ-012 dmem_addr  out  ADDR_WIDTH  doubleword-aligned address (low 3 bits zero).
REQ-013 dmem_wdata, dmem_bmask  out  64, 8  store data and byte mask; bit 7 = byte 0 = [63:56].
REQ-014 dmem_ack, dmem_rdata  in  1, 64  bus completion and big-endian read doubleword.
REQ-015 WB_valid_out, WB_regD_out, WB_regWrite_out, WB_regWriteDouble_out  out  1,5,1,1  write-back control.
REQ-016 WB_data_out  out  64  write-back data; [31:0] for single, {rd,rd+1} = {[63:32],[31:0]} for double.
REQ-017 mem_trap_out  out  1  one-cycle misaligned-access pulse.

Function
REQ-018 States: IDLE, WAIT, DONE; mem_ready = 1 only in IDLE.
REQ-019 IDLE, MEM_valid_in=1, op!=2'b11: register result to WB outputs; WB_valid_out=1 next cycle; stay IDLE; 1-cycle latency.
REQ-020 IDLE, MEM_valid_in=1, op==2'b11, aligned: latch fields; dmem_req=1 from next cycle; go WAIT.
REQ-021 Decoded op3: LD 000000, LDUB 000001, LDUH 000010, LDD 000011, ST 000100, STB 000101, STH 000110, STD 000111, LDSB 001001, LDSH 001010; any other op3 with op==2'b11 is a no-op pass-through with regWrite forced 0.
REQ-022 Alignment: halfword addr[0]=0, word addr[1:0]=0, double addr[2:0]=0; violation -> no bus request, mem_trap_out=1 and WB_valid_out=1 with WB_regWrite_out=0 next cycle; stay IDLE.
REQ-023 WAIT: dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_bmask held constant until dmem_ack=1; no timeout.
REQ-024 WAIT with dmem_ack=1: capture dmem_rdata, deassert dmem_req next cycle, go DONE.
REQ-025 DONE: WB_valid_out=1 for one cycle; go IDLE; mem_ready=1 from the following cycle; minimum memory latency 3 cycles accept-to-WB.
REQ-026 Load extraction, offset k=addr[2:0]: byte = rdata[63-8k -: 8]; halfword/word likewise big-endian; LDUB/LDUH zero-extend, LDSB/LDSH sign-extend to 32.
REQ-027 LDD: WB_data_out = rdata, WB_regWriteDouble_out=1; LD uses rdata[63:32] if addr[2]=0 else [31:0].
REQ-028 Stores: byte/halfword/word from valD[7:0]/[15:0]/[31:0] replicated across all lanes; bmask selects lanes by offset; STD writes valD, bmask=8'hFF; WB_regWrite_out=0.
REQ-029 WB outputs held in the non-valid cycles; consumers qualify with WB_valid_out.
REQ-030 dmem_ack outside WAIT ignored; MEM_valid_in outside IDLE ignored.

Reset
REQ-031 Reset (any state, including WAIT mid-transaction): state IDLE, dmem_req=0, dmem_we=0, WB_valid_out=0, mem_trap_out=0, all WB data/control and dmem address/data/mask 0; mem_ready=1 in the first cycle after reset.

Verification
REQ-032 ADD pass-through, alures=32'h1234 rd=5 regWrite=1 -> next cycle WB_valid_out=1, WB_data_out[31:0]=32'h1234, WB_regD_out=5.
REQ-033 LDSB addr 32'h103, rdata=64'h0000_00F0_0000_0000, ack after 2 cycles -> dmem_addr=32'h100, WB_data_out[31:0]=32'hFFFF_FFF0, mem_ready low until return to IDLE.
REQ-034 STH addr 32'h206, valD[15:0]=16'hBEEF -> dmem_we=1, bmask=8'h03, wdata lanes = BEEF, WB_regWrite_out=0.
REQ-035 LD addr 32'h102 -> no dmem_req, mem_trap_out=1 one cycle, WB_regWrite_out=0.
REQ-036 LDD addr 32'h108, ack 0 cycles later, rdata=64'h1111_2222_3333_4444 -> WB_data_out identical, WB_regWriteDouble_out=1.
REQ-037 Reset asserted in WAIT, stray dmem_ack next cycle -> dmem_req=0 immediately, ack ignored, no WB_valid_out.

Source files
------------

// File: rtl/memory_stage.sv
// Memory pipeline stage: passes ALU results through, and runs single-outstanding
// big-endian loads/stores on a doubleword data bus with alignment trapping.
module memory_stage #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    MEM_valid_in,
  input  logic [31:0]             MEM_alures_in,
  input  logic [DATA_WIDTH-1:0]   MEM_valD_in,
  input  logic [1:0]              MEM_op_in,
  input  logic [5:0]              MEM_op3_in,
  input  logic [4:0]              MEM_regD_in,
  input  logic                    MEM_regWrite_in,
  input  logic                    MEM_regWriteDouble_in,
  output logic                    mem_ready,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic [ADDR_WIDTH-1:0]   dmem_addr,
  output logic [DATA_WIDTH-1:0]   dmem_wdata,
  output logic [DATA_WIDTH/8-1:0] dmem_bmask,
  input  logic                    dmem_ack,
  input  logic [DATA_WIDTH-1:0]   dmem_rdata,
  output logic                    WB_valid_out,
  output logic [4:0]              WB_regD_out,
  output logic                    WB_regWrite_out,
  output logic                    WB_regWriteDouble_out,
  output logic [DATA_WIDTH-1:0]   WB_data_out,
  output logic                    mem_trap_out
);

  localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8;

  localparam logic [1:0] OP_MEM = 2'b11;
  localparam logic [5:0] OP3_LD   = 6'b000000;
  localparam logic [5:0] OP3_LDUB = 6'b000001;
  localparam logic [5:0] OP3_LDUH = 6'b000010;
  localparam logic [5:0] OP3_LDD  = 6'b000011;
  localparam logic [5:0] OP3_ST   = 6'b000100;
  localparam logic [5:0] OP3_STB  = 6'b000101;
  localparam logic [5:0] OP3_STH  = 6'b000110;
  localparam logic [5:0] OP3_STD  = 6'b000111;
  localparam logic [5:0] OP3_LDSB = 6'b001001;
  localparam logic [5:0] OP3_LDSH = 6'b001010;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_DBL  = 2'd3;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [5:0]              op3_q, op3_d;
  logic [2:0]              off_q, off_d;
  logic [4:0]              rd_q, rd_d;
  logic                    rw_q, rw_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic                    ready_d, req_d, we_d, wb_valid_d, trap_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [DATA_WIDTH-1:0]   wdata_d, wb_data_d;
  logic [MASK_WIDTH-1:0]   bmask_d;
  logic [4:0]              wb_regd_d;
  logic                    wb_rw_d, wb_rwd_d;

  logic                    dec_known, dec_store, dec_misalign;
  logic [1:0]              dec_size;
  logic [DATA_WIDTH-1:0]   dec_wdata;
  logic [MASK_WIDTH-1:0]   dec_bmask;

  logic [7:0]              byte_v;
  logic [15:0]             half_v;
  logic [31:0]             word_v, load_v;

  // Decode op3 into access size/direction, alignment check and store lanes
  always_comb begin
    dec_known = 1'b1;
    dec_store = 1'b0;
    dec_size  = SZ_WORD;
    case (MEM_op3_in)
      OP3_LD:             dec_size = SZ_WORD;
      OP3_LDUB, OP3_LDSB: dec_size = SZ_BYTE;
      OP3_LDUH, OP3_LDSH: dec_size = SZ_HALF;
      OP3_LDD:            dec_size = SZ_DBL;
      OP3_ST:  begin dec_store = 1'b1; dec_size = SZ_WORD; end
      OP3_STB: begin dec_store = 1'b1; dec_size = SZ_BYTE; end
      OP3_STH: begin dec_store = 1'b1; dec_size = SZ_HALF; end
      OP3_STD: begin dec_store = 1'b1; dec_size = SZ_DBL;  end
      default: dec_known = 1'b0;
    endcase
    case (dec_size)
      SZ_BYTE: begin
        dec_misalign = 1'b0;
        dec_wdata    = DATA_WIDTH'({8{MEM_valD_in[7:0]}});
        dec_bmask    = MASK_WIDTH'(8'h80 >> MEM_alures_in[2:0]);
      end
      SZ_HALF: begin
        dec_misalign = MEM_alures_in[0];
        dec_wdata    = DATA_WIDTH'({4{MEM_valD_in[15:0]}});
        dec_bmask    = MASK_WIDTH'(8'hC0 >> MEM_alures_in[2:0]);
      end
      SZ_WORD: begin
        dec_misalign = |MEM_alures_in[1:0];
        dec_wdata    = DATA_WIDTH'({2{MEM_valD_in[31:0]}});
        dec_bmask    = MASK_WIDTH'(8'hF0 >> MEM_alures_in[2:0]);
      end
      default: begin
        dec_misalign = |MEM_alures_in[2:0];
        dec_wdata    = MEM_valD_in;
        dec_bmask    = '1;
      end
    endcase
  end

  // Big-endian lane extraction: byte k lives at rdata[63-8k -: 8]
  always_comb begin
    byte_v = 8'(rdata_q >> {~off_q, 3'b000});
    half_v = 16'(rdata_q >> {~off_q & 3'b110, 3'b000});
    word_v = 32'(rdata_q >> {~off_q & 3'b100, 3'b000});
    case (op3_q)
      OP3_LDUB: load_v = {24'h0, byte_v};
      OP3_LDSB: load_v = {{24{byte_v[7]}}, byte_v};
      OP3_LDUH: load_v = {16'h0, half_v};
      OP3_LDSH: load_v = {{16{half_v[15]}}, half_v};
      default:  load_v = word_v;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    req_d      = dmem_req;
    we_d       = dmem_we;
    addr_d     = dmem_addr;
    wdata_d    = dmem_wdata;
    bmask_d    = dmem_bmask;
    wb_valid_d = 1'b0;
    trap_d     = 1'b0;
    wb_regd_d  = WB_regD_out;
    wb_rw_d    = WB_regWrite_out;
    wb_rwd_d   = WB_regWriteDouble_out;
    wb_data_d  = WB_data_out;
    op3_d      = op3_q;
    off_d      = off_q;
    rd_d       = rd_q;
    rw_d       = rw_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (MEM_valid_in) begin
          if (MEM_op_in != OP_MEM || !dec_known) begin
            wb_valid_d = 1'b1;
            wb_regd_d  = MEM_regD_in;
            wb_data_d  = DATA_WIDTH'(MEM_alures_in);
            wb_rw_d    = MEM_regWrite_in && (MEM_op_in != OP_MEM);
            wb_rwd_d   = MEM_regWriteDouble_in && (MEM_op_in != OP_MEM);
          end else if (dec_misalign) begin
            wb_valid_d = 1'b1;
            trap_d     = 1'b1;
            wb_regd_d  = MEM_regD_in;
            wb_data_d  = DATA_WIDTH'(MEM_alures_in);
            wb_rw_d    = 1'b0;
            wb_rwd_d   = 1'b0;
          end else begin
            state_d = WAIT;
            req_d   = 1'b1;
            we_d    = dec_store;
            addr_d  = ADDR_WIDTH'({MEM_alures_in[31:3], 3'b000});
            wdata_d = dec_wdata;
            bmask_d = dec_bmask;
            op3_d   = MEM_op3_in;
            off_d   = MEM_alures_in[2:0];
            rd_d    = MEM_regD_in;
            rw_d    = MEM_regWrite_in && !dec_store;
          end
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          rdata_d = dmem_rdata;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        wb_valid_d = 1'b1;
        wb_regd_d  = rd_q;
        wb_rw_d    = rw_q;
        state_d    = IDLE;
        case (op3_q)
          OP3_LDD: begin
            wb_data_d = rdata_q;
            wb_rwd_d  = 1'b1;
          end
          OP3_ST, OP3_STB, OP3_STH, OP3_STD: wb_rwd_d = 1'b0;
          default: begin
            wb_data_d = DATA_WIDTH'(load_v);
            wb_rwd_d  = 1'b0;
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered outputs and latched transaction fields
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_ready             <= 1'b1;
      dmem_req              <= 1'b0;
      dmem_we               <= 1'b0;
      dmem_addr             <= '0;
      dmem_wdata            <= '0;
      dmem_bmask            <= '0;
      WB_valid_out          <= 1'b0;
      WB_regD_out           <= '0;
      WB_regWrite_out       <= 1'b0;
      WB_regWriteDouble_out <= 1'b0;
      WB_data_out           <= '0;
      mem_trap_out          <= 1'b0;
      op3_q                 <= '0;
      off_q                 <= '0;
      rd_q                  <= '0;
      rw_q                  <= 1'b0;
      rdata_q               <= '0;
    end else begin
      mem_ready             <= ready_d;
      dmem_req              <= req_d;
      dmem_we               <= we_d;
      dmem_addr             <= addr_d;
      dmem_wdata            <= wdata_d;
      dmem_bmask            <= bmask_d;
      WB_valid_out          <= wb_valid_d;
      WB_regD_out           <= wb_regd_d;
      WB_regWrite_out       <= wb_rw_d;
      WB_regWriteDouble_out <= wb_rwd_d;
      WB_data_out           <= wb_data_d;
      mem_trap_out          <= trap_d;
      op3_q                 <= op3_d;
      off_q                 <= off_d;
      rd_q                  <= rd_d;
      rw_q                  <= rw_d;
      rdata_q               <= rdata_d;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage: pass-through, loads, stores,
// misalignment trap and reset during an outstanding bus transaction.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        MEM_valid_in;
  logic [31:0] MEM_alures_in;
  logic [63:0] MEM_valD_in;
  logic [1:0]  MEM_op_in;
  logic [5:0]  MEM_op3_in;
  logic [4:0]  MEM_regD_in;
  logic        MEM_regWrite_in;
  logic        MEM_regWriteDouble_in;
  logic        mem_ready;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_bmask;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;
  logic        WB_valid_out;
  logic [4:0]  WB_regD_out;
  logic        WB_regWrite_out;
  logic        WB_regWriteDouble_out;
  logic [63:0] WB_data_out;
  logic        mem_trap_out;

  int checks = 0;
  int errors = 0;

  // Bus values observed during the last do_mem transaction
  logic        bus_req, bus_we, busy_ready, held_ok, done_req;
  logic [31:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_bmask;

  memory_stage dut (
    .clk                   (clk),
    .reset                 (reset),
    .MEM_valid_in          (MEM_valid_in),
    .MEM_alures_in         (MEM_alures_in),
    .MEM_valD_in           (MEM_valD_in),
    .MEM_op_in             (MEM_op_in),
    .MEM_op3_in            (MEM_op3_in),
    .MEM_regD_in           (MEM_regD_in),
    .MEM_regWrite_in       (MEM_regWrite_in),
    .MEM_regWriteDouble_in (MEM_regWriteDouble_in),
    .mem_ready             (mem_ready),
    .dmem_req              (dmem_req),
    .dmem_we               (dmem_we),
    .dmem_addr             (dmem_addr),
    .dmem_wdata            (dmem_wdata),
    .dmem_bmask            (dmem_bmask),
    .dmem_ack              (dmem_ack),
    .dmem_rdata            (dmem_rdata),
    .WB_valid_out          (WB_valid_out),
    .WB_regD_out           (WB_regD_out),
    .WB_regWrite_out       (WB_regWrite_out),
    .WB_regWriteDouble_out (WB_regWriteDouble_out),
    .WB_data_out           (WB_data_out),
    .mem_trap_out          (mem_trap_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one memory op, ack after 'gap' WAIT cycles, return in the WB-visible cycle
  task automatic do_mem(input logic [5:0] op3, input logic [31:0] addr, input logic [63:0] vald,
                        input logic [63:0] rdata, input int gap, input logic hold_valid);
    MEM_valid_in = 1'b1; MEM_op_in = 2'b11; MEM_op3_in = op3; MEM_alures_in = addr;
    MEM_valD_in = vald; MEM_regD_in = 5'd9; MEM_regWrite_in = 1'b1; MEM_regWriteDouble_in = 1'b0;
    tick();
    MEM_valid_in = hold_valid;
    bus_req = dmem_req; bus_we = dmem_we; bus_addr = dmem_addr;
    bus_wdata = dmem_wdata; bus_bmask = dmem_bmask; busy_ready = mem_ready; held_ok = dmem_req;
    for (int i = 0; i < gap; i++) begin
      tick();
      busy_ready = busy_ready | mem_ready;
      held_ok = held_ok && dmem_req && (dmem_addr == bus_addr) && (dmem_wdata == bus_wdata)
                && (dmem_bmask == bus_bmask) && (dmem_we == bus_we);
    end
    MEM_valid_in = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = rdata;
    tick();
    dmem_ack = 1'b0; dmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    done_req = dmem_req;
    busy_ready = busy_ready | mem_ready;
    tick();
  endtask

  initial begin
    reset = 1'b1; MEM_valid_in = 1'b0; MEM_alures_in = '0; MEM_valD_in = '0; MEM_op_in = '0;
    MEM_op3_in = '0; MEM_regD_in = '0; MEM_regWrite_in = 1'b0; MEM_regWriteDouble_in = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    tick(); tick();
    chk("rst_ready", 64'(mem_ready), 64'd1);
    chk("rst_req", 64'(dmem_req), 64'd0);
    chk("rst_wbvalid", 64'(WB_valid_out), 64'd0);
    chk("rst_trap", 64'(mem_trap_out), 64'd0);
    chk("rst_wbdata", WB_data_out, 64'd0);
    chk("rst_addr", 64'(dmem_addr), 64'd0);
    reset = 1'b0;
    tick();

    // ADD pass-through
    MEM_valid_in = 1'b1; MEM_op_in = 2'b10; MEM_op3_in = 6'b000000; MEM_alures_in = 32'h1234;
    MEM_regD_in = 5'd5; MEM_regWrite_in = 1'b1;
    tick();
    MEM_valid_in = 1'b0;
    chk("add_valid", 64'(WB_valid_out), 64'd1);
    chk("add_data", 64'(WB_data_out[31:0]), 64'h1234);
    chk("add_rd", 64'(WB_regD_out), 64'd5);
    chk("add_rw", 64'(WB_regWrite_out), 64'd1);
    chk("add_noreq", 64'(dmem_req), 64'd0);
    tick();
    chk("add_valid_drop", 64'(WB_valid_out), 64'd0);
    chk("add_data_held", 64'(WB_data_out[31:0]), 64'h1234);

    // LDSB 0x103, ack after 2 WAIT cycles, valid held high while busy
    do_mem(6'b001001, 32'h103, 64'h0, 64'h0000_00F0_0000_0000, 2, 1'b1);
    chk("ldsb_req", 64'(bus_req), 64'd1);
    chk("ldsb_we", 64'(bus_we), 64'd0);
    chk("ldsb_addr", 64'(bus_addr), 64'h100);
    chk("ldsb_busy_ready", 64'(busy_ready), 64'd0);
    chk("ldsb_held", 64'(held_ok), 64'd1);
    chk("ldsb_done_req", 64'(done_req), 64'd0);
    chk("ldsb_valid", 64'(WB_valid_out), 64'd1);
    chk("ldsb_data", 64'(WB_data_out[31:0]), 64'hFFFF_FFF0);
    chk("ldsb_rd", 64'(WB_regD_out), 64'd9);
    chk("ldsb_rw", 64'(WB_regWrite_out), 64'd1);
    chk("ldsb_ready", 64'(mem_ready), 64'd1);
    tick();
    chk("ldsb_valid_drop", 64'(WB_valid_out), 64'd0);
    chk("ldsb_no_reissue", 64'(dmem_req), 64'd0);

    // STH 0x206
    do_mem(6'b000110, 32'h206, 64'h0000_0000_0000_BEEF, 64'h0, 0, 1'b0);
    chk("sth_we", 64'(bus_we), 64'd1);
    chk("sth_addr", 64'(bus_addr), 64'h200);
    chk("sth_bmask", 64'(bus_bmask), 64'h03);
    chk("sth_wdata", bus_wdata, 64'hBEEF_BEEF_BEEF_BEEF);
    chk("sth_valid", 64'(WB_valid_out), 64'd1);
    chk("sth_rw", 64'(WB_regWrite_out), 64'd0);

    // STB 0x305
    do_mem(6'b000101, 32'h305, 64'h0000_0000_0000_00A5, 64'h0, 1, 1'b0);
    chk("stb_bmask", 64'(bus_bmask), 64'h04);
    chk("stb_wdata", bus_wdata, 64'hA5A5_A5A5_A5A5_A5A5);
    chk("stb_held", 64'(held_ok), 64'd1);

    // STD 0x3F8
    do_mem(6'b000111, 32'h3F8, 64'hCAFE_F00D_0BAD_BEEF, 64'h0, 0, 1'b0);
    chk("std_bmask", 64'(bus_bmask), 64'hFF);
    chk("std_wdata", bus_wdata, 64'hCAFE_F00D_0BAD_BEEF);
    chk("std_addr", 64'(bus_addr), 64'h3F8);

    // LD misaligned 0x102
    MEM_valid_in = 1'b1; MEM_op_in = 2'b11; MEM_op3_in = 6'b000000; MEM_alures_in = 32'h102;
    MEM_regWrite_in = 1'b1;
    tick();
    MEM_valid_in = 1'b0;
    chk("mis_req", 64'(dmem_req), 64'd0);
    chk("mis_trap", 64'(mem_trap_out), 64'd1);
    chk("mis_valid", 64'(WB_valid_out), 64'd1);
    chk("mis_rw", 64'(WB_regWrite_out), 64'd0);
    chk("mis_ready", 64'(mem_ready), 64'd1);
    tick();
    chk("mis_trap_drop", 64'(mem_trap_out), 64'd0);
    chk("mis_req_after", 64'(dmem_req), 64'd0);

    // LDD 0x108, ack in first WAIT cycle
    do_mem(6'b000011, 32'h108, 64'h0, 64'h1111_2222_3333_4444, 0, 1'b0);
    chk("ldd_addr", 64'(bus_addr), 64'h108);
    chk("ldd_data", WB_data_out, 64'h1111_2222_3333_4444);
    chk("ldd_dbl", 64'(WB_regWriteDouble_out), 64'd1);
    chk("ldd_valid", 64'(WB_valid_out), 64'd1);

    // LD word at offset 4 and LDUH at offset 4
    do_mem(6'b000000, 32'h104, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 1'b0);
    chk("ld4_data", 64'(WB_data_out[31:0]), 64'h89AB_CDEF);
    chk("ld4_dbl", 64'(WB_regWriteDouble_out), 64'd0);
    do_mem(6'b000010, 32'h10C, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 1'b0);
    chk("lduh_data", 64'(WB_data_out[31:0]), 64'h0000_89AB);

    // Unknown op3 with op=3: pass-through, no write
    MEM_valid_in = 1'b1; MEM_op_in = 2'b11; MEM_op3_in = 6'b111111; MEM_alures_in = 32'h77;
    tick();
    MEM_valid_in = 1'b0;
    chk("nop_valid", 64'(WB_valid_out), 64'd1);
    chk("nop_rw", 64'(WB_regWrite_out), 64'd0);
    chk("nop_req", 64'(dmem_req), 64'd0);

    // Reset while in WAIT, then a stray ack
    MEM_valid_in = 1'b1; MEM_op_in = 2'b11; MEM_op3_in = 6'b000000; MEM_alures_in = 32'h110;
    tick();
    MEM_valid_in = 1'b0;
    chk("rw_req", 64'(dmem_req), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rw_req_clr", 64'(dmem_req), 64'd0);
    chk("rw_ready", 64'(mem_ready), 64'd1);
    chk("rw_addr_clr", 64'(dmem_addr), 64'd0);
    dmem_ack = 1'b1; dmem_rdata = 64'h5555_5555_5555_5555;
    tick();
    dmem_ack = 1'b0;
    chk("rw_no_wb1", 64'(WB_valid_out), 64'd0);
    chk("rw_req_idle", 64'(dmem_req), 64'd0);
    tick();
    chk("rw_no_wb2", 64'(WB_valid_out), 64'd0);
    chk("rw_ready2", 64'(mem_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
